// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data access (DM).
// Data wins ties, but after STARVE_MAX back-to-back data grants a waiting fetch is forced through.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_ack,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            arb_busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          owner_dm;
  logic          grant_dm;

  // Data is preferred unless fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_dm = dm_req && !(if_req && starve_cnt == STARVE_LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_ack     <= 1'b0;
      dm_rdata   <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      arb_busy   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req || if_req) begin
            owner_dm  <= grant_dm;
            mem_valid <= 1'b1;
            arb_busy  <= 1'b1;
            state     <= ISSUE;
            if (grant_dm) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_be    <= dm_we ? dm_be : '1;
              if (!if_req)
                starve_cnt <= '0;
              else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + CW'(1);
            end else begin
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              mem_be     <= '1;
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        // Stores complete through mem_rvalid too, but leave dm_rdata untouched.
        WAIT: begin
          if (mem_rvalid) begin
            state <= RESP;
            if (owner_dm) begin
              dm_ack <= 1'b1;
              if (!mem_we)
                dm_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
